// File: rtl/voice_mix_engine.sv
// voice_mix_engine: time-multiplexed voice mixer producing a truncated average
// or saturating sum of the enabled voices, one voice accumulated per clock.
module voice_mix_engine #(
    parameter int NUM_VOICES = 12,
    parameter int SAMPLE_W   = 8,
    localparam int CNT_W     = $clog2(NUM_VOICES + 1),
    localparam int ACC_W     = SAMPLE_W + $clog2(NUM_VOICES)
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           start,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] samples,
    input  logic [NUM_VOICES-1:0]          sample_enable,
    input  logic                           mix_mode,
    output logic                           busy,
    output logic                           out_valid,
    output logic [SAMPLE_W-1:0]            out_sample,
    output logic [CNT_W-1:0]               active_count
);
    localparam int IDX_W = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam int DC_W  = $clog2(ACC_W);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

    state_t                         state;
    logic [NUM_VOICES*SAMPLE_W-1:0] sh_samples;
    logic [NUM_VOICES-1:0]          sh_en;
    logic                           sh_mode;
    logic [ACC_W-1:0]               acc;
    logic [CNT_W-1:0]               cnt;
    logic [CNT_W-1:0]               rem;
    logic [IDX_W-1:0]               idx;
    logic [DC_W-1:0]                dcnt;

    logic [SAMPLE_W-1:0] cur;
    logic                hit;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [ACC_W-1:0]    acc_nxt;
    logic [CNT_W:0]      trial;
    logic                ge;
    logic [SAMPLE_W-1:0] sat;

    // During DIVIDE, acc doubles as the dividend shifter and collects quotient bits at its LSB.
    always_comb begin
        cur     = sh_samples[idx*SAMPLE_W +: SAMPLE_W];
        hit     = sh_en[idx];
        cnt_nxt = cnt + CNT_W'(hit);
        acc_nxt = acc + ACC_W'(cur & {SAMPLE_W{hit}});
        trial   = {rem, acc[ACC_W-1]};
        ge      = trial >= {1'b0, cnt};
        sat     = (acc > ACC_W'({SAMPLE_W{1'b1}})) ? {SAMPLE_W{1'b1}} : acc[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            sh_samples   <= '0;
            sh_en        <= '0;
            sh_mode      <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            rem          <= '0;
            idx          <= '0;
            dcnt         <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_sample   <= '0;
            active_count <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sh_samples <= samples;
                    sh_en      <= sample_enable;
                    sh_mode    <= mix_mode;
                    acc        <= '0;
                    cnt        <= '0;
                    idx        <= '0;
                    busy       <= 1'b1;
                    state      <= ACCUM;
                end
                ACCUM: begin
                    acc  <= acc_nxt;
                    cnt  <= cnt_nxt;
                    idx  <= idx + IDX_W'(1);
                    rem  <= '0;
                    dcnt <= DC_W'(ACC_W - 1);
                    if (idx == IDX_W'(NUM_VOICES - 1))
                        state <= (!sh_mode && cnt_nxt > CNT_W'(1)) ? DIVIDE : DONE;
                end
                DIVIDE: begin
                    acc  <= {acc[ACC_W-2:0], ge};
                    rem  <= ge ? CNT_W'(trial - {1'b0, cnt}) : trial[CNT_W-1:0];
                    dcnt <= dcnt - DC_W'(1);
                    if (dcnt == '0)
                        state <= DONE;
                end
                default: begin
                    out_sample   <= sh_mode ? sat : acc[SAMPLE_W-1:0];
                    active_count <= cnt;
                    out_valid    <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_voice_mix_engine.sv
// tb_voice_mix_engine: table-driven checks of the voice mixer plus hand-written
// sequences for mid-mix input changes, ignored starts and asynchronous reset.
module tb_voice_mix_engine;
    localparam int NV = 12;
    localparam int SW = 8;
    localparam int CW = $clog2(NV + 1);

    typedef struct {
        logic [NV*SW-1:0] s;
        logic [NV-1:0]    en;
        logic             mode;
        int               exp_s;
        int               exp_c;
        int               lat;
    } vec_t;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic [NV*SW-1:0] samples = '0;
    logic [NV-1:0]    sample_enable = '0;
    logic             mix_mode = 1'b0;
    logic             busy;
    logic             out_valid;
    logic [SW-1:0]    out_sample;
    logic [CW-1:0]    active_count;

    int checks = 0;
    int errors = 0;
    vec_t vecs[10];
    logic [NV*SW-1:0] s;

    voice_mix_engine #(.NUM_VOICES(NV), .SAMPLE_W(SW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .samples(samples),
        .sample_enable(sample_enable), .mix_mode(mix_mode), .busy(busy),
        .out_valid(out_valid), .out_sample(out_sample), .active_count(active_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NV*SW-1:0] sv, input logic [NV-1:0] en,
                                input logic mode, input int es, input int ec, input int lat);
        vec_t v;
        v.s = sv; v.en = en; v.mode = mode; v.exp_s = es; v.exp_c = ec; v.lat = lat;
        return v;
    endfunction

    task automatic run_mix(input vec_t v, input bit disturb, input string tag);
        int n = 0;
        bit done = 0;
        bit busy_ok = 1;
        @(negedge clk);
        samples = v.s; sample_enable = v.en; mix_mode = v.mode; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            samples = '0; sample_enable = '1; mix_mode = ~mix_mode;
        end
        while (n < 60 && !done) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) done = 1;
            else begin
                if (!busy) busy_ok = 0;
                if (disturb) start = (n == 4 || n == v.lat - 1);
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, n, v.lat);
        chk({tag, " out_sample"}, int'(out_sample), v.exp_s);
        chk({tag, " active_count"}, int'(active_count), v.exp_c);
        chk({tag, " busy_low_at_valid"}, int'(busy), 0);
        chk({tag, " busy_high_during_mix"}, int'(busy_ok), 1);
        @(posedge clk); #1;
        chk({tag, " valid_one_cycle"}, int'(out_valid), 0);
    endtask

    task automatic quiet(input int cycles, input string tag);
        int hits = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        chk({tag, " no_extra_valid"}, hits, 0);
    endtask

    initial begin
        s = {NV{8'hFF}};
        vecs[0] = mk(s, 12'hFFF, 1'b0, 255, 12, 25);
        s = {NV{8'hFF}}; s[0+:8] = 8'd10; s[8+:8] = 8'd20; s[16+:8] = 8'd31;
        vecs[1] = mk(s, 12'h007, 1'b0, 20, 3, 25);
        s = {NV{8'h33}}; s[0+:8] = 8'd200; s[40+:8] = 8'd100;
        vecs[2] = mk(s, 12'h021, 1'b1, 255, 2, 13);
        s[0+:8] = 8'd40; s[40+:8] = 8'd50;
        vecs[3] = mk(s, 12'h021, 1'b1, 90, 2, 13);
        s = {NV{8'hFF}};
        vecs[4] = mk(s, 12'h000, 1'b0, 0, 0, 13);
        s = {NV{8'h11}}; s[56+:8] = 8'h5A;
        vecs[5] = mk(s, 12'h080, 1'b0, 8'h5A, 1, 13);
        s = {NV{8'hFF}};
        vecs[6] = mk(s, 12'hFFF, 1'b1, 255, 12, 13);
        s = {NV{8'hFF}}; s[8+:8] = 8'd1; s[16+:8] = 8'd2;
        vecs[7] = mk(s, 12'h006, 1'b0, 1, 2, 25);
        s = '0; s[24+:8] = 8'd250; s[88+:8] = 8'd7;
        vecs[8] = mk(s, 12'h808, 1'b0, 128, 2, 25);
        s = {NV{8'hEE}}; s[88+:8] = 8'h80;
        vecs[9] = mk(s, 12'h800, 1'b1, 128, 1, 13);

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_sample", int'(out_sample), 0);
        chk("reset active_count", int'(active_count), 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 10; i++) run_mix(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Inputs scrambled after capture, start pulsed while busy and on the DONE edge.
        run_mix(vecs[1], 1'b1, "disturb");
        quiet(30, "disturb");

        run_mix(vecs[0], 1'b0, "pre_reset");
        @(negedge clk);
        samples = vecs[0].s; sample_enable = vecs[0].en; mix_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("async_reset busy", int'(busy), 0);
        chk("async_reset out_valid", int'(out_valid), 0);
        chk("async_reset out_sample", int'(out_sample), 0);
        chk("async_reset active_count", int'(active_count), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        quiet(40, "after_reset");
        run_mix(vecs[1], 1'b0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
